loss_batch_acc: RTL and testbench
=================================

# loss_batch_acc

Downstream consumer of the per-sample squared-error loss stage. Accumulates a batch of 2^BATCH_LOG2 loss values into a full-precision sum and reports the truncated batch mean to the training controller over a valid/ready handshake. An optional tracker also reports the largest single-sample loss in the batch.

## Interface
- LOSS_W, 46: width of incoming per-sample loss.
- BATCH_LOG2, 3: log2 of batch size; batch = 8 samples by default. Legal range 1..8.
- ACC_W, LOSS_W+BATCH_LOG2: sum width (derived; not overridden).

- clk_i  in  1  single clock, rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- start_i  in  1  begin a new batch (pulse).
- loss_valid_i  in  1  loss_i carries a sample this cycle.
- loss_i  in  LOSS_W  unsigned per-sample loss (registered output of the loss stage).
- busy_o  out  1  high while in ACCUM.
- cnt_o  out  BATCH_LOG2+1  samples accepted in current batch.
- sum_o  out  ACC_W  batch sum.
- mean_o  out  LOSS_W  sum_o >> BATCH_LOG2 (truncated).
- max_o  out  LOSS_W  largest sample in batch (see Configuration).
- mean_valid_o  out  1  result available.
- mean_ready_i  in  1  controller accepts result.

## Operation
- States: IDLE, ACCUM, DONE.
- IDLE: loss_valid_i ignored. start_i -> ACCUM; clears sum, cnt, max.
- ACCUM: each cycle with loss_valid_i=1 adds loss_i to sum, increments cnt, updates max. On acceptance of sample number 2^BATCH_LOG2 -> DONE.
- ACCUM + start_i: restart; sum/cnt/max cleared, any loss_valid_i that cycle discarded, stay ACCUM.
- DONE: mean_valid_o=1; sum_o, mean_o, max_o, cnt_o held stable; loss_valid_i ignored. mean_valid_o && mean_ready_i -> IDLE. If start_i is also high in that cycle -> ACCUM directly (cleared). start_i without ready: ignored.
- Arithmetic: unsigned; ACC_W guarantees no overflow; no saturation logic. mean_o is floor division.
- Results remain visible in IDLE until the next start_i clears them.

## Timing
- Reset (rst_i=0 at edge): state IDLE; busy_o, cnt_o, sum_o, mean_o, max_o, mean_valid_o all 0. Reset mid-batch or mid-DONE discards everything, no result emitted.
- Sample accepted at edge where ACCUM && loss_valid_i; sum_o/cnt_o reflect it the following cycle.
- mean_valid_o rises the cycle after the final sample edge (1-cycle latency); mean_o combinationally tied to registered sum_o.
- mean_valid_o stays high until the handshake edge; it drops the cycle after.
- Back-to-back samples every cycle supported; gaps allowed without limit.

## Configuration
- LOSS_BATCH_ACC_MAX_EN defined: max register and compare logic built; max_o = max of accepted samples (0 after clear).
- Undefined: no max register; max_o tied to 0. All other behaviour identical.

## Structure
- Shared package loss_pkg: LOSS_W constant, state enum type (IDLE/ACCUM/DONE), default BATCH_LOG2.
- One natural sub-module: loss_max_trk (registered running max with clear), instantiated only under LOSS_BATCH_ACC_MAX_EN.

## Test plan
- Defaults, start_i, 8 consecutive samples of 16 -> one cycle after 8th: mean_valid_o=1, sum_o=128, mean_o=16, cnt_o=8; with macro max_o=16.
- Samples 1..8 with idle gaps, mean_ready_i held low 5 cycles -> sum_o=36, mean_o=4 (truncated 4.5), outputs stable all 5 cycles, drop one cycle after ready.
- 8 samples of 2^46-1 -> sum_o=2^49-8, mean_o=2^46-1, no wrap.
- Restart: 3 samples of 100, then start_i with loss_valid_i=1, then 8 samples of 1 -> sum_o=8, cnt_o=8 (earlier samples discarded).
- Reset asserted after 5 samples -> next cycle all outputs 0, state IDLE; further loss_valid_i ignored until start_i.
- DONE with mean_ready_i=1 and start_i=1 same cycle -> next cycle busy_o=1, cnt_o=0, sum_o=0, mean_valid_o=0; macro-off build: max_o=0 throughout.

Source files
------------

// File: rtl/loss_pkg.sv
// Shared definitions for the loss batch accumulator: loss width, default batch size, FSM states.
package loss_pkg;

   localparam int LOSS_W         = 46;
   localparam int BATCH_LOG2_DEF = 3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } loss_state_e;

endpackage

// File: rtl/loss_batch_acc_if.sv
// Sample stream, batch control and result channel of loss_batch_acc.
interface loss_batch_acc_if #(
   parameter int BATCH_LOG2 = loss_pkg::BATCH_LOG2_DEF
);

   localparam int LOSS_W = loss_pkg::LOSS_W;
   localparam int ACC_W  = LOSS_W + BATCH_LOG2;

   logic                  start_i;
   logic                  loss_valid_i;
   logic [LOSS_W-1:0]     loss_i;
   logic                  busy_o;
   logic [BATCH_LOG2:0]   cnt_o;
   logic [ACC_W-1:0]      sum_o;
   logic [LOSS_W-1:0]     mean_o;
   logic [LOSS_W-1:0]     max_o;
   logic                  mean_valid_o;
   logic                  mean_ready_i;

   // Result transfers on a rising edge where mean_valid_o && mean_ready_i; once raised,
   // mean_valid_o and all result fields hold until that edge. loss_valid_i has no ready:
   // a sample is taken whenever the block is accumulating, and ignored otherwise.
   modport master (
      output start_i, loss_valid_i, loss_i, mean_ready_i,
      input  busy_o, cnt_o, sum_o, mean_o, max_o, mean_valid_o
   );

   modport slave (
      input  start_i, loss_valid_i, loss_i, mean_ready_i,
      output busy_o, cnt_o, sum_o, mean_o, max_o, mean_valid_o
   );

endinterface

// File: rtl/loss_max_trk.sv
// Registered running maximum with synchronous clear.
module loss_max_trk #(
   parameter int W = 46
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clr_i,
   input  logic         upd_i,
   input  logic [W-1:0] val_i,
   output logic [W-1:0] max_o
);

   logic [W-1:0] max_q;

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         max_q <= '0;
      end else if (clr_i) begin
         max_q <= '0;
      end else if (upd_i && (val_i > max_q)) begin
         max_q <= val_i;
      end
   end

   assign max_o = max_q;

endmodule

// File: rtl/loss_batch_acc.sv
// Accumulates 2^BATCH_LOG2 per-sample losses and hands the truncated mean to the controller.
// Define LOSS_BATCH_ACC_MAX_EN to also track the largest sample of the batch on max_o.
module loss_batch_acc
   import loss_pkg::*;
#(
   parameter int BATCH_LOG2 = BATCH_LOG2_DEF
) (
   input  logic            clk_i,
   input  logic            rst_i,
   loss_batch_acc_if.slave bus,
   output loss_state_e     state_o
);

   localparam int ACC_W = LOSS_W + BATCH_LOG2;
   localparam int CNT_W = BATCH_LOG2 + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << BATCH_LOG2) - 1);

   loss_state_e      state_q, state_d;
   logic [ACC_W-1:0] sum_q;
   logic [CNT_W-1:0] cnt_q;
   logic             clr;
   logic             acc;

   always_comb begin
      state_d = state_q;
      clr     = 1'b0;
      acc     = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start_i) begin
               state_d = ACCUM;
               clr     = 1'b1;
            end
         end
         ACCUM: begin
            // A restart wins over a sample arriving in the same cycle.
            if (bus.start_i) begin
               clr = 1'b1;
            end else if (bus.loss_valid_i) begin
               acc = 1'b1;
               if (cnt_q == CNT_LAST) state_d = DONE;
            end
         end
         DONE: begin
            if (bus.mean_ready_i) begin
               if (bus.start_i) begin
                  state_d = ACCUM;
                  clr     = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         sum_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (clr) begin
            sum_q <= '0;
            cnt_q <= '0;
         end else if (acc) begin
            sum_q <= sum_q + ACC_W'(bus.loss_i);
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign state_o          = state_q;
   assign bus.busy_o       = (state_q == ACCUM);
   assign bus.mean_valid_o = (state_q == DONE);
   assign bus.cnt_o        = cnt_q;
   assign bus.sum_o        = sum_q;
   // Dropping the low BATCH_LOG2 bits is the floor of sum / batch size.
   assign bus.mean_o       = sum_q[ACC_W-1:BATCH_LOG2];

`ifdef LOSS_BATCH_ACC_MAX_EN
   logic [LOSS_W-1:0] max_q;

   loss_max_trk #(
      .W (LOSS_W)
   ) u_max_trk (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clr),
      .upd_i (acc),
      .val_i (bus.loss_i),
      .max_o (max_q)
   );

   assign bus.max_o = max_q;
`else
   assign bus.max_o = '0;
`endif

endmodule

// File: tb/tb_loss_batch_acc.sv
// Randomized and directed bench for loss_batch_acc with a queue-based result scoreboard.
module tb_loss_batch_acc;
   import loss_pkg::*;

   localparam int BL2   = BATCH_LOG2_DEF;
   localparam int BATCH = 1 << BL2;
   localparam int ACC_W = LOSS_W + BL2;
   localparam int CNT_W = BL2 + 1;
   localparam int EXP_W = CNT_W + ACC_W + 2 * LOSS_W;

   // ---------------- clock / reset ----------------
   logic clk   = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk = ~clk;

   loss_batch_acc_if #(.BATCH_LOG2(BL2)) bus ();
   loss_state_e state_o;

   loss_batch_acc #(.BATCH_LOG2(BL2)) dut (
      .clk_i   (clk),
      .rst_i   (rst_i),
      .bus     (bus),
      .state_o (state_o)
   );

   int n_vec = 0;
   int n_err = 0;

   logic [EXP_W-1:0]  exp_q[$];
   logic [LOSS_W-1:0] batch_q[$];
   bit                in_batch = 1'b0;

   task automatic check(input string name, input logic [EXP_W-1:0] act, input logic [EXP_W-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [ACC_W-1:0] q_sum();
      logic [ACC_W-1:0] s = '0;
      foreach (batch_q[i]) s += ACC_W'(batch_q[i]);
      return s;
   endfunction

   function automatic logic [EXP_W-1:0] batch_result();
      logic [ACC_W-1:0]  s = q_sum();
      logic [LOSS_W-1:0] m = LOSS_W'(s / ACC_W'(BATCH));
      logic [LOSS_W-1:0] mx = '0;
`ifdef LOSS_BATCH_ACC_MAX_EN
      foreach (batch_q[i]) if (batch_q[i] > mx) mx = batch_q[i];
`endif
      return {CNT_W'(BATCH), s, m, mx};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      bus.start_i = 1'b1;
      step();
      bus.start_i = 1'b0;
      batch_q.delete();
      in_batch = 1'b1;
      check("start_busy", EXP_W'(bus.busy_o), EXP_W'(1));
      check("start_cnt", EXP_W'(bus.cnt_o), EXP_W'(0));
      check("start_sum", EXP_W'(bus.sum_o), EXP_W'(0));
   endtask

   task automatic send_sample(input logic [LOSS_W-1:0] v);
      bit done_now = 1'b0;
      bus.loss_valid_i = 1'b1;
      bus.loss_i       = v;
      step();
      bus.loss_valid_i = 1'b0;
      if (in_batch) begin
         batch_q.push_back(v);
         if (batch_q.size() == BATCH) begin
            exp_q.push_back(batch_result());
            in_batch = 1'b0;
            done_now = 1'b1;
         end
      end
      check("cnt", EXP_W'(bus.cnt_o), EXP_W'(batch_q.size()));
      check("sum", EXP_W'(bus.sum_o), EXP_W'(q_sum()));
      if (done_now) check("valid_latency", EXP_W'(bus.mean_valid_o), EXP_W'(1));
      else if (in_batch) check("valid_early", EXP_W'(bus.mean_valid_o), EXP_W'(0));
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic wait_result(input int delay, input bit with_start);
      int t = 0;
      while (!bus.mean_valid_o && t < 50) begin
         step();
         t++;
      end
      if (!bus.mean_valid_o) begin
         n_vec++;
         n_err++;
         $display("FAIL result_timeout: mean_valid_o stayed 0 for %0d cycles", t);
         return;
      end
      repeat (delay) step();
      bus.mean_ready_i = 1'b1;
      bus.start_i      = with_start;
      step();
      bus.mean_ready_i = 1'b0;
      bus.start_i      = 1'b0;
      check("valid_drop", EXP_W'(bus.mean_valid_o), EXP_W'(0));
      if (with_start) begin
         batch_q.delete();
         in_batch = 1'b1;
         check("ready_start_busy", EXP_W'(bus.busy_o), EXP_W'(1));
         check("ready_start_cnt", EXP_W'(bus.cnt_o), EXP_W'(0));
         check("ready_start_sum", EXP_W'(bus.sum_o), EXP_W'(0));
         check("ready_start_max", EXP_W'(bus.max_o), EXP_W'(0));
      end else begin
         check("idle_busy", EXP_W'(bus.busy_o), EXP_W'(0));
         check("idle_state", EXP_W'(state_o), EXP_W'(IDLE));
         check("idle_hold_sum", EXP_W'(bus.sum_o), EXP_W'(q_sum()));
      end
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      step();
      rst_i = 1'b1;
      batch_q.delete();
      exp_q.delete();
      in_batch = 1'b0;
      check("rst_state", EXP_W'(state_o), EXP_W'(IDLE));
      check("rst_outs", {bus.cnt_o, bus.sum_o, bus.mean_o, bus.max_o}, '0);
      check("rst_flags", EXP_W'({bus.busy_o, bus.mean_valid_o}), EXP_W'(0));
   endtask

   function automatic logic [LOSS_W-1:0] rand_loss();
      return LOSS_W'({$urandom(), $urandom()});
   endfunction

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      if (rst_i && bus.mean_valid_o) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_result: sum %0h with no result expected", bus.sum_o);
         end else begin
            check("result", {bus.cnt_o, bus.sum_o, bus.mean_o, bus.max_o}, exp_q[0]);
            if (bus.mean_ready_i) void'(exp_q.pop_front());
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [ACC_W-1:0] all_ones_sum;
      bus.start_i      = 1'b0;
      bus.loss_valid_i = 1'b0;
      bus.loss_i       = '0;
      bus.mean_ready_i = 1'b0;
      idle(2);
      do_reset();
      send_sample(LOSS_W'(77));

      // Eight samples of 16 back to back.
      do_start();
      repeat (BATCH) send_sample(LOSS_W'(16));
      check("t1_sum", EXP_W'(bus.sum_o), EXP_W'(128));
      check("t1_mean", EXP_W'(bus.mean_o), EXP_W'(16));
      wait_result(0, 1'b0);

      // 1..8 with idle gaps, controller stalls 5 cycles.
      do_start();
      for (int i = 1; i <= BATCH; i++) begin
         send_sample(LOSS_W'(i));
         idle(i % 3);
      end
      check("t2_mean", EXP_W'(bus.mean_o), EXP_W'(4));
      wait_result(5, 1'b0);

      // Largest possible samples must not wrap.
      do_start();
      repeat (BATCH) send_sample({LOSS_W{1'b1}});
      all_ones_sum = {ACC_W{1'b1}} - ACC_W'(7);
      check("t3_sum", EXP_W'(bus.sum_o), EXP_W'(all_ones_sum));
      check("t3_mean", EXP_W'(bus.mean_o), EXP_W'({LOSS_W{1'b1}}));
      wait_result(1, 1'b0);

      // Restart mid-batch; the sample presented with start_i is discarded.
      do_start();
      repeat (3) send_sample(LOSS_W'(100));
      bus.start_i      = 1'b1;
      bus.loss_valid_i = 1'b1;
      bus.loss_i       = LOSS_W'(100);
      step();
      bus.start_i      = 1'b0;
      bus.loss_valid_i = 1'b0;
      batch_q.delete();
      in_batch = 1'b1;
      check("restart_cnt", EXP_W'(bus.cnt_o), EXP_W'(0));
      repeat (BATCH) send_sample(LOSS_W'(1));
      check("t4_sum", EXP_W'(bus.sum_o), EXP_W'(8));
      wait_result(0, 1'b0);

      // Reset after 5 samples, then samples in IDLE are ignored.
      do_start();
      repeat (5) send_sample(rand_loss());
      do_reset();
      repeat (3) send_sample(rand_loss());

      // Reset while a result is pending.
      do_start();
      repeat (BATCH) send_sample(rand_loss());
      idle(2);
      do_reset();

      // Handshake and start in the same cycle.
      do_start();
      repeat (BATCH) send_sample(rand_loss());
      wait_result(1, 1'b1);
      repeat (BATCH) send_sample(rand_loss());
      wait_result(0, 1'b0);

      // Randomized batches with gaps, ignored samples in DONE/IDLE and random stalls.
      for (int b = 0; b < 8; b++) begin
         do_start();
         for (int i = 0; i < BATCH; i++) begin
            idle($urandom_range(0, 2));
            send_sample(rand_loss());
         end
         if ($urandom_range(0, 1) == 1) send_sample(rand_loss());
         wait_result($urandom_range(0, 3), 1'b0);
         if ($urandom_range(0, 1) == 1) send_sample(rand_loss());
      end

      idle(3);
      if (exp_q.size() != 0) begin
         n_vec++;
         n_err++;
         $display("FAIL leftover_results: %0d expected results never seen", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
